// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one AXI-Lite UART TX path among several byte streams.
// Each byte polls the status register until the TX FIFO has room, then writes it; packets lock the grant.
module uart_tx_scheduler #(
    parameter int           NUM_REQ   = 4,
    parameter int           POLL_WAIT = 8,
    parameter logic [3:0]   TX_ADDR   = 4'h4,
    parameter logic [3:0]   STAT_ADDR = 4'h8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [3:0]             m_aw_addr_o,
    output logic                   m_aw_valid_o,
    input  logic                   m_aw_ready_i,
    output logic [31:0]            m_w_data_o,
    output logic [3:0]             m_w_strb_o,
    output logic                   m_w_valid_o,
    input  logic                   m_w_ready_i,
    input  logic [1:0]             m_b_resp_i,
    input  logic                   m_b_valid_i,
    output logic                   m_b_ready_o,
    output logic [3:0]             m_ar_addr_o,
    output logic                   m_ar_valid_o,
    input  logic                   m_ar_ready_i,
    input  logic [31:0]            m_r_data_i,
    input  logic [1:0]             m_r_resp_i,
    input  logic                   m_r_valid_i,
    output logic                   m_r_ready_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(POLL_WAIT + 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        RD_STAT,
        WAIT_R,
        POLL,
        WR,
        WAIT_B
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            locked_q, locked_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic            pick_ok;
    logic [IW-1:0]   pick_idx;
    logic            aw_fin, w_fin;
    logic [NUM_REQ-1:0] onehot;
    logic            rdata_unused;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return s[IW-1:0];
    endfunction

    // Scan downward so the nearest requester after rr_ptr wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = idx_q;
        if (locked_q) begin
            pick_ok = req_valid_i[idx_q];
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
                    pick_ok  = 1'b1;
                    pick_idx = wrap_add(rr_ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        locked_d  = locked_q;
        rr_ptr_d  = rr_ptr_q;
        aw_fin    = aw_done_q | m_aw_ready_i;
        w_fin     = w_done_q | m_w_ready_i;
        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    idx_d   = pick_idx;
                    data_d  = req_data_i[{pick_idx, 3'b000} +: 8];
                    last_d  = req_last_i[pick_idx];
                    state_d = RD_STAT;
                end
            end
            RD_STAT: begin
                if (m_ar_ready_i) state_d = WAIT_R;
            end
            WAIT_R: begin
                if (m_r_valid_i) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (m_r_resp_i != 2'b00) begin
                        state_d = WR;
                    end else if (m_r_data_i[3]) begin
                        state_d = POLL;
                        cnt_d   = CW'(POLL_WAIT);
                    end else begin
                        state_d = WR;
                    end
                end
            end
            POLL: begin
                // Leaving as the count reaches zero gives POLL_WAIT idle cycles between reads.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = RD_STAT;
            end
            WR: begin
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WAIT_B;
                end
            end
            WAIT_B: begin
                if (m_b_valid_i) begin
                    state_d = IDLE;
                    if (last_q) begin
                        locked_d = 1'b0;
                        rr_ptr_d = idx_q;
                    end else begin
                        locked_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            locked_q  <= 1'b0;
            rr_ptr_q  <= IW'(NUM_REQ - 1);
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            locked_q  <= locked_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign onehot       = ONE << idx_q;
    assign grant_o      = (state_q != IDLE || locked_q) ? onehot : '0;
    assign busy_o       = (state_q != IDLE);
    assign m_ar_addr_o  = STAT_ADDR;
    assign m_ar_valid_o = (state_q == RD_STAT);
    assign m_r_ready_o  = (state_q == WAIT_R);
    assign m_aw_addr_o  = TX_ADDR;
    assign m_aw_valid_o = (state_q == WR) && !aw_done_q;
    assign m_w_data_o   = {24'h0, data_q};
    assign m_w_strb_o   = 4'h1;
    assign m_w_valid_o  = (state_q == WR) && !w_done_q;
    assign m_b_ready_o  = (state_q == WAIT_B);

    // Pulses are suppressed in a reset cycle so an abandoned transaction reports nothing.
    assign req_ready_o  = (state_q == WAIT_B && m_b_valid_i && !rst_i) ? onehot : '0;
    assign err_o        = !rst_i &&
                          ((state_q == WAIT_R && m_r_valid_i && m_r_resp_i != 2'b00) ||
                           (state_q == WAIT_B && m_b_valid_i && m_b_resp_i != 2'b00));

    assign rdata_unused = ^{m_r_data_i[31:4], m_r_data_i[2:0]};

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a randomized AXI-Lite slave plus a queue-based model of the
// round-robin/packet-lock service order; directed cases followed by random packet mixes.
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int PW = 8;

    typedef struct packed {logic [3:0] r; logic [7:0] d; logic last;} item_t;
    typedef struct packed {logic [31:0] data; logic [1:0] resp;} rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_valid, req_last, req_ready, grant;
    logic [8*NR-1:0]   req_data;
    logic              busy, err;
    logic [3:0]        aw_addr, w_strb, ar_addr;
    logic              aw_valid, aw_ready, w_valid, w_ready;
    logic [31:0]       w_data, r_data;
    logic [1:0]        b_resp, r_resp;
    logic              b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;

    uart_tx_scheduler #(.NUM_REQ(NR), .POLL_WAIT(PW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .grant_o(grant), .busy_o(busy), .err_o(err),
        .m_aw_addr_o(aw_addr), .m_aw_valid_o(aw_valid), .m_aw_ready_i(aw_ready),
        .m_w_data_o(w_data), .m_w_strb_o(w_strb), .m_w_valid_o(w_valid), .m_w_ready_i(w_ready),
        .m_b_resp_i(b_resp), .m_b_valid_i(b_valid), .m_b_ready_o(b_ready),
        .m_ar_addr_o(ar_addr), .m_ar_valid_o(ar_valid), .m_ar_ready_i(ar_ready),
        .m_r_data_i(r_data), .m_r_resp_i(r_resp), .m_r_valid_i(r_valid), .m_r_ready_o(r_ready)
    );

    item_t      pend[$];
    item_t      expq[$];
    rd_t        stat_q[$];
    logic [1:0] bresp_q[$];

    int tests = 0, fails = 0, cyc = 0;
    int m_ptr = NR - 1, m_lock = -1;
    int r_cnt = -1, b_cnt = -1;
    bit aw_got, w_got, hold_wr, rnd_slave, poll_chk, ar_prev, busy_s, aw_seen;
    int r_cyc, ar_count, err_seen, exp_err, served, first_idx, owner = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    function automatic item_t mk(input int r, input logic [7:0] d, input logic l);
        item_t e;
        e.r = 4'(r); e.d = d; e.last = l;
        return e;
    endfunction

    // Service order from the rules: lock owner first, else nearest valid after the pointer.
    task automatic build_model();
        item_t tmp[$];
        int r, jj;
        tmp = pend;
        expq.delete();
        while (tmp.size() > 0) begin
            r = -1;
            if (m_lock >= 0) r = m_lock;
            else
                for (int k = 1; k <= NR; k++)
                    for (int j = 0; j < tmp.size(); j++)
                        if (r < 0 && int'(tmp[j].r) == (m_ptr + k) % NR) r = (m_ptr + k) % NR;
            jj = -1;
            for (int j = 0; j < tmp.size(); j++)
                if (jj < 0 && int'(tmp[j].r) == r) jj = j;
            if (jj < 0) break;
            expq.push_back(tmp[jj]);
            if (tmp[jj].last) begin m_lock = -1; m_ptr = r; end
            else m_lock = r;
            tmp.delete(jj);
        end
    endtask

    task automatic clear_bench();
        req_valid = '0; req_data = '0; req_last = '0;
        aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_valid = 0; b_resp = 0; r_valid = 0; r_resp = 0; r_data = 0;
        pend.delete(); expq.delete(); stat_q.delete(); bresp_q.delete();
        r_cnt = -1; b_cnt = -1; aw_got = 0; w_got = 0; hold_wr = 0;
        poll_chk = 0; ar_prev = 0; owner = -1; m_ptr = NR - 1; m_lock = -1;
    endtask

    task automatic drive(input bit hs_r, input bit hs_b);
        rd_t e;
        logic [1:0] br;
        bit f;
        if (hs_r) r_valid = 0;
        if (r_cnt == 0) begin
            if (stat_q.size() > 0) e = stat_q.pop_front();
            else if (rnd_slave) begin
                e.data = ($urandom_range(0, 3) == 0) ? 32'h8 : 32'h0;
                e.resp = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            end else e = '0;
            r_valid = 1;
            r_data  = rnd_slave ? (($urandom & ~32'h8) | e.data) : e.data;
            r_resp  = e.resp;
            r_cnt   = -1;
        end else if (r_cnt > 0) r_cnt--;
        if (hs_b) b_valid = 0;
        if (b_cnt == 0) begin
            if (bresp_q.size() > 0) br = bresp_q.pop_front();
            else br = (rnd_slave && $urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            b_valid = 1; b_resp = br; b_cnt = -1;
        end else if (b_cnt > 0) b_cnt--;
        ar_ready = 1'($urandom_range(0, 1));
        aw_ready = hold_wr ? 1'b0 : 1'($urandom_range(0, 1));
        w_ready  = hold_wr ? 1'b0 : 1'($urandom_range(0, 1));
        req_valid = '0; req_data = '0; req_last = '0;
        for (int r = 0; r < NR; r++) begin
            f = 0;
            for (int j = 0; j < pend.size(); j++)
                if (!f && int'(pend[j].r) == r) begin
                    f = 1;
                    req_valid[r] = 1'b1;
                    req_data[8*r +: 8] = pend[j].d;
                    req_last[r] = pend[j].last;
                end
        end
    endtask

    task automatic step();
        bit hs_r, hs_b, f;
        item_t e;
        @(negedge clk);
        hs_r = r_valid && r_ready;
        hs_b = b_valid && b_ready;
        busy_s = busy;
        aw_seen = aw_valid;
        if (!rst) begin
            if (ar_valid && !ar_prev && poll_chk) begin
                chk("poll_gap", 32'(cyc - r_cyc), 32'(PW + 1));
                poll_chk = 0;
            end
            ar_prev = ar_valid;
            if (ar_valid && ar_ready) begin
                chk("ar_addr", 32'(ar_addr), 32'h8);
                ar_count++;
                r_cnt = $urandom_range(0, 2);
            end
            if (hs_r) begin
                if (r_resp != 2'b00) exp_err++;
                else if (r_data[3]) begin poll_chk = 1; r_cyc = cyc; end
            end
            if (aw_valid && aw_ready) begin
                chk("aw_addr", 32'(aw_addr), 32'h4);
                aw_got = 1;
            end
            if (w_valid && w_ready) begin
                chk("w_strb", 32'(w_strb), 32'h1);
                if (expq.size() > 0) begin
                    chk("w_data", w_data, {24'h0, expq[0].d});
                    chk("grant_wr", 32'(grant), oh(int'(expq[0].r)));
                end else chk("w_unexpected", 32'(expq.size()), 32'd1);
                w_got = 1;
            end
            if (aw_got && w_got) begin
                b_cnt = $urandom_range(0, 2);
                aw_got = 0; w_got = 0;
            end
            if (hs_b && b_resp != 2'b00) exp_err++;
            if (err) err_seen++;
            if (req_ready != '0) begin
                if (expq.size() == 0) chk("rdy_unexpected", 32'(req_ready), 32'd0);
                else begin
                    e = expq.pop_front();
                    chk("req_ready", 32'(req_ready), oh(int'(e.r)));
                    chk("grant_rdy", 32'(grant), oh(int'(e.r)));
                    if (served == 0) first_idx = int'(e.r);
                    served++;
                    f = 0;
                    for (int j = 0; j < pend.size(); j++)
                        if (!f && pend[j].r == e.r) begin f = 1; pend.delete(j); end
                    owner = e.last ? -1 : int'(e.r);
                end
            end else if (owner >= 0) chk("grant_lock", 32'(grant), oh(owner));
        end
        @(posedge clk);
        cyc++;
        #1;
        drive(hs_r, hs_b);
    endtask

    task automatic run_scen(input string tag);
        int n, t;
        build_model();
        n = expq.size();
        ar_count = 0; err_seen = 0; exp_err = 0; served = 0; first_idx = -1;
        t = 0;
        do begin step(); t++; end
        while (!(pend.size() == 0 && expq.size() == 0 && !busy_s) && t < 6000);
        chk({tag, "_timeout"}, 32'(t < 6000), 32'd1);
        chk({tag, "_left"}, 32'(expq.size()), 32'd0);
        chk({tag, "_served"}, 32'(served), 32'(n));
        chk({tag, "_err"}, 32'(err_seen), 32'(exp_err));
        step();
        chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        clear_bench();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, np, nb;
        rst = 1;
        rnd_slave = 0;
        clear_bench();
        do_reset();
        @(negedge clk);
        chk("rst_ar_valid", 32'(ar_valid), 0);
        chk("rst_aw_valid", 32'(aw_valid), 0);
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_ready", 32'({r_ready, b_ready}), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy_err", 32'({busy, err}), 0);

        pend.push_back(mk(0, 8'h41, 1));
        run_scen("single");
        chk("single_reads", 32'(ar_count), 1);
        chk("single_first", 32'(first_idx), 0);

        pend.push_back(mk(1, 8'h11, 1));
        pend.push_back(mk(2, 8'h22, 1));
        run_scen("rr12");
        chk("rr12_first", 32'(first_idx), 1);

        pend.push_back(mk(0, 8'h30, 1));
        pend.push_back(mk(3, 8'h33, 1));
        run_scen("rr03");
        chk("rr03_first", 32'(first_idx), 3);

        pend.push_back(mk(1, 8'h41, 0));
        pend.push_back(mk(1, 8'h42, 1));
        pend.push_back(mk(2, 8'h58, 1));
        pend.push_back(mk(0, 8'h59, 1));
        run_scen("lock");
        chk("lock_first", 32'(first_idx), 1);

        pend.push_back(mk(2, 8'h77, 1));
        for (int i = 0; i < 3; i++) stat_q.push_back('{data: 32'h8, resp: 2'b00});
        stat_q.push_back('{data: 32'h0, resp: 2'b00});
        run_scen("poll");
        chk("poll_reads", 32'(ar_count), 4);

        pend.push_back(mk(3, 8'h5e, 1));
        bresp_q.push_back(2'b10);
        run_scen("berr");
        chk("berr_pulses", 32'(err_seen), 1);

        hold_wr = 1;
        pend.push_back(mk(2, 8'h5a, 1));
        t = 0;
        do begin step(); t++; end while (!aw_seen && t < 200);
        chk("midrst_reach_wr", 32'(aw_seen), 1);
        @(posedge clk); #1;
        rst = 1;
        clear_bench();
        @(negedge clk);
        chk("midrst_rdy", 32'(req_ready), 0);
        chk("midrst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_valids", 32'({ar_valid, aw_valid, w_valid}), 0);
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_busy", 32'(busy), 0);
        repeat (3) step();
        chk("midrst_quiet", 32'({req_ready, err}), 0);

        rnd_slave = 1;
        for (int s = 0; s < 12; s++) begin
            for (int r = 0; r < NR; r++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++)
                        pend.push_back(mk(r, 8'($urandom), b == nb - 1));
                end
            end
            run_scen("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
